// File: rtl/vector_dot_master.sv
// vector_dot_master: Avalon-MM initiator that streams operand pairs into a vector_dot slave and returns its result
// Ports: clk/reset_n (async active-low); in_valid/in_ready/in_a/in_b/in_last operand stream;
//        m_address/m_writedata/m_write/m_read/m_readdata/m_waitrequest slave bus;
//        res_valid/res_data/res_ready result stream; pair_cnt pairs issued this vector; busy when not idle.
module vector_dot_master #(
  parameter int RD_LATENCY = 1,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic in_last,
  output logic [1:0] m_address,
  output logic [31:0] m_writedata,
  output logic m_write,
  output logic m_read,
  input  logic [31:0] m_readdata,
  input  logic m_waitrequest,
  output logic res_valid,
  output logic [31:0] res_data,
  input  logic res_ready,
  output logic [CNT_W-1:0] pair_cnt,
  output logic busy
);
  typedef enum logic [2:0] {IDLE, WR_A, WR_B, DRAIN, RD, RD_WAIT, DONE} state_t;
  state_t state, state_n;
  logic [31:0] a, a_n, b, b_n, res_n;
  logic last, last_n;
  logic [2:0] lat, lat_n;
  logic [CNT_W-1:0] cnt_n;
  always_comb begin
    state_n = state;
    a_n = a;
    b_n = b;
    last_n = last;
    lat_n = lat;
    res_n = res_data;
    cnt_n = pair_cnt;
    case (state)
      IDLE: if (in_valid && in_ready) begin
        a_n = in_a;
        b_n = in_b;
        last_n = in_last;
        state_n = WR_A;
      end
      WR_A: if (!m_waitrequest) state_n = WR_B;
      WR_B: if (!m_waitrequest) begin
        cnt_n = &pair_cnt ? pair_cnt : pair_cnt + 1'b1;
        state_n = last ? DRAIN : IDLE;
      end
      DRAIN: if (!m_waitrequest) state_n = RD;
      RD: if (!m_waitrequest) begin
        if (RD_LATENCY == 0) begin
          res_n = m_readdata;
          state_n = DONE;
        end else begin
          lat_n = 3'(RD_LATENCY);
          state_n = RD_WAIT;
        end
      end
      RD_WAIT: begin
        lat_n = lat - 3'd1;
        if (lat == 3'd1) begin
          res_n = m_readdata;
          state_n = DONE;
        end
      end
      DONE: if (res_ready) begin
        cnt_n = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // Outputs are registered from the next state so each bus strobe and its
  // address/data appear together and hold steady across waitrequest stalls.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      a <= '0;
      b <= '0;
      last <= 1'b0;
      lat <= '0;
      res_data <= '0;
      pair_cnt <= '0;
      in_ready <= 1'b0;
      busy <= 1'b0;
      res_valid <= 1'b0;
      m_write <= 1'b0;
      m_read <= 1'b0;
      m_address <= '0;
      m_writedata <= '0;
    end else begin
      state <= state_n;
      a <= a_n;
      b <= b_n;
      last <= last_n;
      lat <= lat_n;
      res_data <= res_n;
      pair_cnt <= cnt_n;
      in_ready <= state_n == IDLE;
      busy <= state_n != IDLE;
      res_valid <= state_n == DONE;
      m_write <= state_n inside {WR_A, WR_B, DRAIN};
      m_read <= state_n == RD;
      m_address <= {1'b0, state_n == WR_B};
      m_writedata <= state_n == WR_A ? a_n : state_n == WR_B ? b_n : '0;
    end
endmodule

// File: tb/tb_vector_dot_master.sv
// tb_vector_dot_master: directed self-checking bench for vector_dot_master
module tb_vector_dot_master;
  logic clk = 0, reset_n = 0;
  logic in_valid = 0, lv = 0, in_last = 0, res_ready = 1, wr = 0;
  logic [31:0] in_a = 0, in_b = 0, rv = 0;
  int cyc = 0, rdc0 = -100, rdc1 = -100, rdc3 = -100;
  int compared = 0, mism = 0;
  logic [34:0] bus_log[$], exp_log[$];
  logic in_ready, m_write, m_read, res_valid, busy;
  logic [1:0] m_address;
  logic [31:0] m_writedata, m_readdata, res_data;
  logic [15:0] pair_cnt;
  logic in_ready0, m_write0, m_read0, res_valid0, busy0;
  logic [1:0] m_address0;
  logic [31:0] m_writedata0, rdata0, res_data0;
  logic [15:0] pair_cnt0;
  logic in_ready3, m_write3, m_read3, res_valid3, busy3;
  logic [1:0] m_address3;
  logic [31:0] m_writedata3, rdata3, res_data3;
  logic [15:0] pair_cnt3;

  vector_dot_master #(.RD_LATENCY(1), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .m_address(m_address),
    .m_writedata(m_writedata), .m_write(m_write), .m_read(m_read),
    .m_readdata(m_readdata), .m_waitrequest(wr), .res_valid(res_valid),
    .res_data(res_data), .res_ready(res_ready), .pair_cnt(pair_cnt), .busy(busy));

  vector_dot_master #(.RD_LATENCY(0), .CNT_W(16)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(lv), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .m_address(m_address0),
    .m_writedata(m_writedata0), .m_write(m_write0), .m_read(m_read0),
    .m_readdata(rdata0), .m_waitrequest(1'b0), .res_valid(res_valid0),
    .res_data(res_data0), .res_ready(1'b1), .pair_cnt(pair_cnt0), .busy(busy0));

  vector_dot_master #(.RD_LATENCY(3), .CNT_W(16)) dut3 (
    .clk(clk), .reset_n(reset_n), .in_valid(lv), .in_ready(in_ready3),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .m_address(m_address3),
    .m_writedata(m_writedata3), .m_write(m_write3), .m_read(m_read3),
    .m_readdata(rdata3), .m_waitrequest(1'b0), .res_valid(res_valid3),
    .res_data(res_data3), .res_ready(1'b1), .pair_cnt(pair_cnt3), .busy(busy3));

  always #5 clk = ~clk;

  // Slave models: read data is the expected result only in the exact cycle the
  // latency says it is valid, junk otherwise, so a mistimed capture shows up.
  assign m_readdata = (cyc == rdc1 + 1) ? rv : 32'hDEADBEEF;
  assign rdata0 = m_read0 ? rv : 32'hDEADBEEF;
  assign rdata3 = (cyc == rdc3 + 3) ? rv : 32'hDEADBEEF;

  always @(posedge clk) begin
    if ((m_write || m_read) && !wr) bus_log.push_back({m_write, m_address, m_writedata});
    if (m_read && !wr) rdc1 <= cyc;
    if (m_read0) rdc0 <= cyc;
    if (m_read3) rdc3 <= cyc;
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mism++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  always @(negedge clk)
    if (reset_n)
      chk("bus_idle", 64'((m_write && m_read) || (!m_write && !m_read && (m_address != 0 || m_writedata != 0))), 0);

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic l);
    int n = 0;
    in_a = a;
    in_b = b;
    in_last = l;
    in_valid = 1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_res();
    int n = 0;
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("res_valid_seen", res_valid, 1);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_len"}, bus_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size(); i++)
      chk($sformatf("%s_%0d", tag, i), (i < bus_log.size()) ? bus_log[i] : 35'h7FFFFFFFF, exp_log[i]);
    bus_log.delete();
  endtask

  initial begin
    bit s0, s3;
    int d0, d3;
    logic [31:0] r0, r3;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_pair_cnt", pair_cnt, 0);
    chk("rst_m_write", m_write, 0);
    reset_n = 1;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);
    // three-pair vector: 1*2 + 3*4 + 5*6 = 44.0
    rv = 32'h42300000;
    send(32'h3F800000, 32'h40000000, 0);
    send(32'h40400000, 32'h40800000, 0);
    send(32'h40A00000, 32'h40C00000, 1);
    wait_res();
    chk("t1_res_data", res_data, 32'h42300000);
    chk("t1_pair_cnt", pair_cnt, 3);
    chk("t1_rd_to_valid", cyc - rdc1, 2);
    @(negedge clk);
    chk("t1_pulse", res_valid, 0);
    chk("t1_in_ready", in_ready, 1);
    exp_log = '{35'h43F800000, 35'h540000000, 35'h440400000, 35'h540800000,
                35'h440A00000, 35'h540C00000, 35'h400000000, 35'h000000000};
    check_log("t1_bus");
    // single pair: 2*3 = 6.0
    rv = 32'h40C00000;
    send(32'h40000000, 32'h40400000, 1);
    wait_res();
    chk("t2_res_data", res_data, 32'h40C00000);
    chk("t2_pair_cnt", pair_cnt, 1);
    @(negedge clk);
    exp_log = '{35'h440000000, 35'h540400000, 35'h400000000, 35'h000000000};
    check_log("t2_bus");
    // 3-cycle stall during WR_B of pair 2
    rv = 32'h42300000;
    send(32'h3F800000, 32'h40000000, 0);
    send(32'h40400000, 32'h40800000, 0);
    @(negedge clk);
    wr = 1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_hold_write", m_write, 1);
      chk("t3_hold_addr", m_address, 1);
      chk("t3_hold_data", m_writedata, 32'h40800000);
      if (i == 3) wr = 0;
      @(negedge clk);
    end
    send(32'h40A00000, 32'h40C00000, 1);
    wait_res();
    chk("t3_res_data", res_data, 32'h42300000);
    @(negedge clk);
    exp_log = '{35'h43F800000, 35'h540000000, 35'h440400000, 35'h540800000,
                35'h440A00000, 35'h540C00000, 35'h400000000, 35'h000000000};
    check_log("t3_bus");
    // result backpressure with a new pair waiting
    res_ready = 0;
    rv = 32'h40C00000;
    send(32'h40000000, 32'h40400000, 1);
    wait_res();
    in_a = 32'h3F800000;
    in_b = 32'h40000000;
    in_last = 1;
    in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", res_valid, 1);
      chk("t4_in_ready", in_ready, 0);
      chk("t4_hold_data", res_data, 32'h40C00000);
      @(negedge clk);
    end
    res_ready = 1;
    chk("t4_hs_valid", res_valid, 1);
    chk("t4_hs_in_ready", in_ready, 0);
    @(negedge clk);
    chk("t4_idle_in_ready", in_ready, 1);
    chk("t4_idle_valid", res_valid, 0);
    chk("t4_idle_cnt", pair_cnt, 0);
    chk("t4_idle_busy", busy, 0);
    @(negedge clk);
    in_valid = 0;
    rv = 32'h40000000;
    chk("t4_new_busy", busy, 1);
    chk("t4_new_write", m_write, 1);
    chk("t4_new_data", m_writedata, 32'h3F800000);
    wait_res();
    chk("t4_res_data", res_data, 32'h40000000);
    @(negedge clk);
    exp_log = '{35'h440000000, 35'h540400000, 35'h400000000, 35'h000000000,
                35'h43F800000, 35'h540000000, 35'h400000000, 35'h000000000};
    check_log("t4_bus");
    // reset during DRAIN, then 3*4 = 12.0
    rv = 32'h41400000;
    send(32'h40400000, 32'h40800000, 1);
    @(negedge clk);
    @(negedge clk);
    chk("t5_drain_write", m_write, 1);
    chk("t5_drain_data", m_writedata, 0);
    chk("t5_drain_cnt", pair_cnt, 1);
    #2 reset_n = 0;
    #1;
    chk("t5_rst_write", m_write, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_cnt", pair_cnt, 0);
    chk("t5_rst_in_ready", in_ready, 0);
    @(negedge clk);
    reset_n = 1;
    chk("t5_rel_in_ready", in_ready, 0);
    @(negedge clk);
    chk("t5_in_ready", in_ready, 1);
    exp_log = '{35'h440400000, 35'h540800000};
    check_log("t5_abort_bus");
    send(32'h40400000, 32'h40800000, 1);
    wait_res();
    chk("t5_res_data", res_data, 32'h41400000);
    chk("t5_pair_cnt", pair_cnt, 1);
    @(negedge clk);
    exp_log = '{35'h440400000, 35'h540800000, 35'h400000000, 35'h000000000};
    check_log("t5_bus");
    // RD_LATENCY 0 and 3: 5*6 = 30.0
    rv = 32'h41F00000;
    in_a = 32'h40A00000;
    in_b = 32'h40C00000;
    in_last = 1;
    chk("t6_ready0", in_ready0, 1);
    chk("t6_ready3", in_ready3, 1);
    lv = 1;
    @(negedge clk);
    lv = 0;
    s0 = 0;
    s3 = 0;
    d0 = -1;
    d3 = -1;
    r0 = 0;
    r3 = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (res_valid0 && !s0) begin
        s0 = 1;
        d0 = cyc - rdc0;
        r0 = res_data0;
      end
      if (res_valid3 && !s3) begin
        s3 = 1;
        d3 = cyc - rdc3;
        r3 = res_data3;
      end
    end
    chk("t6_seen0", s0, 1);
    chk("t6_lat0", d0, 1);
    chk("t6_data0", r0, 32'h41F00000);
    chk("t6_seen3", s3, 1);
    chk("t6_lat3", d3, 4);
    chk("t6_data3", r3, 32'h41F00000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule

// File: doc/vector_dot_master.md
# vector_dot_master

Avalon-MM initiator that drives the `vector_dot` floating-point dot-product slave. It accepts operand pairs from an upstream valid/ready stream and issues the slave's register write sequence: A to address 0, B to address 1, then a drain write of 0 to address 0. It then reads the accumulated result from address 0 and presents it on a result handshake. The block sits between an operand source (DMA/FIFO) and the `vector_dot` slave, replacing manual bus sequencing.

## Interface
- `RD_LATENCY`, 1: cycles from the read being accepted to `m_readdata` being valid; legal range 0–7.
- `CNT_W`, 16: width of the pair counter.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: block accepts a pair this cycle.
- `in_a` in 32: IEEE-754 single operand A.
- `in_b` in 32: IEEE-754 single operand B.
- `in_last` in 1: pair is the last element of the vector.
- `m_address` out 2: slave register address.
- `m_writedata` out 32: slave write data.
- `m_write` out 1: write strobe.
- `m_read` out 1: read strobe.
- `m_readdata` in 32: slave read data.
- `m_waitrequest` in 1: slave stall; tie to 0 for a slave with no stall.
- `res_valid` out 1: result valid.
- `res_data` out 32: dot-product result.
- `res_ready` in 1: downstream accepts the result.
- `pair_cnt` out CNT_W: pairs issued in the current vector.
- `busy` out 1: state is not IDLE.

## Operation
- States: IDLE, WR_A, WR_B, DRAIN, RD, RD_WAIT, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: latch a, b and last into holding registers, go to WR_A.
- WR_A: `m_write`=1, `m_address`=0, `m_writedata`=a. Hold until `m_waitrequest`=0, then go to WR_B.
- WR_B: `m_write`=1, `m_address`=1, `m_writedata`=b. On completion:
  - `pair_cnt`++ (saturating at all-ones).
  - Go to DRAIN if last, else IDLE.
- DRAIN: `m_write`=1, `m_address`=0, `m_writedata`=0. On completion go to RD.
- RD: `m_read`=1, `m_address`=0. On completion load the latency counter with RD_LATENCY and go to RD_WAIT.
- RD_WAIT:
  - Decrement the latency counter.
  - At 0, capture `m_readdata` into `res_data`, go to DONE.
  - RD_LATENCY=0: capture in the same cycle the read completes and go straight to DONE (RD_WAIT is skipped).
- DONE:
  - `res_valid`=1 and `res_data` stable until `res_ready`=1.
  - Then `pair_cnt`←0, go to IDLE.
- `m_write` and `m_read` are never asserted together. `m_address` and `m_writedata` are 0 when no strobe is active.
- Operands pass through unmodified; the block does no arithmetic on data.
- `in_ready` is 0 in every state except IDLE, so a new vector cannot start before the previous result is accepted.
- Reset mid-operation:
  - All state is cleared immediately and any in-flight bus transaction is abandoned without completion.
  - The slave is reset by the same system reset.

## Timing
- All outputs are registered. Reset values:
  - `in_ready`=0 while `reset_n`=0, then 1 from the first cycle after release.
  - All other outputs are 0 (state IDLE).
- With `m_waitrequest`=0:
  - Each pair costs 3 cycles: accept, WR_A, WR_B.
  - The last pair is followed by DRAIN (1), RD (1), RD_WAIT (RD_LATENCY).
  - `res_valid` rises RD_LATENCY+1 cycles after the RD cycle.
- Each bus command is a one-cycle pulse, extended by one cycle for every cycle `m_waitrequest`=1. Address, data and strobe hold steady during a stall.
- `res_valid` with `res_ready` already high: exactly a 1-cycle pulse; IDLE and `in_ready` follow on the next cycle.
- `in_valid` asserted during DONE is ignored until IDLE; the upstream must hold it.

## Test plan
- Vector (1.0,2.0),(3.0,4.0),(5.0,6.0) = 3F800000/40000000, 40400000/40800000, 40A00000/40C00000, last on the third pair, slave model, RD_LATENCY=1, waitrequest=0 ->
  - Bus order: W0/3F800000, W1/40000000, W0/40400000, W1/40800000, W0/40A00000, W1/40C00000, W0/00000000, R0.
  - `res_data`=42300000 (44.0), `pair_cnt`=3 while `res_valid`=1.
- Single pair (40000000, 40400000) with last=1 -> 4 bus commands; `res_data`=40C00000 (6.0).
- `m_waitrequest` high for 3 cycles during WR_B of pair 2 -> address, data and strobe held 4 cycles; same result 42300000; no duplicate write.
- `res_ready`=0 for 5 cycles in DONE, `in_valid` high with a new pair -> `res_valid` held 5 cycles, `in_ready`=0 throughout, new pair accepted only in the cycle after the handshake.
- `reset_n` pulsed low during DRAIN -> all outputs 0 asynchronously, `pair_cnt`=0; a following 1-pair vector completes correctly.
- RD_LATENCY=0 and RD_LATENCY=3 -> `res_valid` asserts 1 and 4 cycles after the R0 cycle respectively, with the correct data captured.
